// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared execute-stage constants used by the divider.
//   - div_state_e            : divider FSM state encodings
//   - DivResultReady/NotReady: ready flag levels
//   - DivStart/DivStop       : start request levels
//   - EXE_DIV_OP/EXE_DIVU_OP : alu op codes steered to the divider
package ex_div_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div_step.sv
// div_step: one combinational radix-2 restoring iteration.
// Ports:
//   partial  in  WIDTH+1  shifted partial remainder with the next dividend bit in bit 0
//   divisor  in  WIDTH    divisor magnitude
//   rem_next out WIDTH    partial remainder after the step
//   q_bit    out 1        quotient bit produced by the step
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] diff;

   // partial < 2*divisor, so the WIDTH+1 bit difference cannot wrap and its
   // top bit is a valid sign.
   assign diff     = partial - {1'b0, divisor};
   assign q_bit    = ~diff[WIDTH];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/ex_div.sv
// ex_div: iterative signed/unsigned divider for the execute stage.
// One quotient bit per clock; busy_o stalls the pipeline while it works.
// Ports:
//   clk        in  1        clock
//   rst        in  1        synchronous active-high reset
//   start_i    in  1        division request, held until ready_o
//   annul_i    in  1        abort current/pending division
//   signed_i   in  1        1 = DIV, 0 = DIVU (sampled on acceptance)
//   opdata1_i  in  WIDTH    dividend (sampled on acceptance)
//   opdata2_i  in  WIDTH    divisor  (sampled on acceptance)
//   result_o   out 2*WIDTH  {remainder, quotient}
//   ready_o    out 1        result_o valid
//   busy_o     out 1        combinational stall request
module ex_div
   import ex_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   div_state_e       state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;     // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] rem;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] rem_next;
   logic             q_bit;
   logic             accept;
   logic [WIDTH-1:0] quo_final;

   function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] x);
      return c ? ((~x) + WIDTH'(1)) : x;
   endfunction

   div_step #(.WIDTH(WIDTH)) u_step (
      .partial  ({rem, dvd[WIDTH-1]}),
      .divisor  (dsr),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   assign accept    = (state == DivFree) && (start_i == DivStart) && !annul_i;
   assign quo_final = {dvd[WIDTH-2:0], q_bit};

   always_ff @(posedge clk) begin
      if (rst) state <= DivFree;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy_o  = 1'b0;
      case (state)
         DivFree: begin
            if (accept) begin
               busy_o  = 1'b1;
               state_n = (opdata2_i == '0) ? DivByZero : DivOn;
            end
         end
         DivByZero: begin
            busy_o  = 1'b1;
            state_n = annul_i ? DivFree : DivEnd;
         end
         DivOn: begin
            busy_o = 1'b1;
            if (annul_i)          state_n = DivFree;
            else if (cnt == LAST) state_n = DivEnd;
         end
         DivEnd: begin
            // annul in END is treated the same as the execute stage letting go
            if ((start_i == DivStop) || annul_i) state_n = DivFree;
         end
         default: state_n = DivFree;
      endcase
      if (rst) busy_o = 1'b0;
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         result_o <= '0;
         ready_o  <= DivResultNotReady;
      end else begin
         case (state)
            DivFree: if (accept) cnt <= '0;
            DivByZero: begin
               result_o <= '0;
               ready_o  <= annul_i ? DivResultNotReady : DivResultReady;
            end
            DivOn: begin
               if (annul_i) begin
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     result_o <= {neg_if(neg_r, rem_next), neg_if(neg_q, quo_final)};
                     ready_o  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if ((start_i == DivStop) || annul_i) begin
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath: operand capture on acceptance, one restoring step per ON cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         dvd   <= neg_if(signed_i && opdata1_i[WIDTH-1], opdata1_i);
         dsr   <= neg_if(signed_i && opdata2_i[WIDTH-1], opdata2_i);
         rem   <= '0;
         neg_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
         neg_r <= signed_i && opdata1_i[WIDTH-1];
      end else if (state == DivOn) begin
         rem <= rem_next;
         dvd <= quo_final;
      end
   end

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

   localparam int WIDTH = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic               start_i;
   logic               annul_i;
   logic               signed_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
   logic               busy_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ex_div #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .annul_i   (annul_i),
      .signed_i  (signed_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .result_o  (result_o),
      .ready_o   (ready_o),
      .busy_o    (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts busy cycles from request to completion, then checks the result.
   // glitch: change the operands a few cycles in. hold: keep start_i high in END.
   task automatic run_div(input string tag, input logic sg,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int exp_busy,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input bit glitch, input bit hold);
      int cycles;
      logic [2*WIDTH-1:0] exp_res;
      exp_res   = {er, eq};
      signed_i  = sg;
      opdata1_i = a;
      opdata2_i = b;
      start_i   = 1'b1;
      #1;
      cycles = 0;
      while (busy_o && cycles < 100) begin
         cycles++;
         step();
         if (glitch && cycles == 3) begin
            opdata1_i = 32'h1234_5678;
            opdata2_i = 32'h0000_0003;
            signed_i  = ~sg;
         end
      end
      chk({tag, "_busy"}, 64'(cycles), 64'(exp_busy));
      chk({tag, "_ready"}, 64'(ready_o), 64'd1);
      chk({tag, "_result"}, result_o, exp_res);
      if (hold) begin
         repeat (5) step();
         chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
         chk({tag, "_hold_busy"}, 64'(busy_o), 64'd0);
         chk({tag, "_hold_result"}, result_o, exp_res);
      end
      start_i = 1'b0;
      step();
      chk({tag, "_clr_ready"}, 64'(ready_o), 64'd0);
      chk({tag, "_clr_result"}, result_o, 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start_i   = 1'b1;
      annul_i   = 1'b0;
      signed_i  = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      #1;
      chk("rst_busy", 64'(busy_o), 64'd0);
      step();
      step();
      chk("rst_busy2", 64'(busy_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      start_i = 1'b0;
      rst     = 1'b0;
      step();

      run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0);
      step();
      run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      step();
      run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
      step();
      run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
      step();
      run_div("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
      step();
      run_div("by_zero", 1'b0, 32'd5, 32'd0, 2, 32'd0, 32'd0, 1'b0, 1'b0);
      step();
      run_div("glitch", 1'b0, 32'd1000, 32'd7, 33, 32'd142, 32'd6, 1'b1, 1'b0);
      step();

      // annul on the 10th ON cycle, then an immediate new start
      signed_i  = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      step();                 // accept edge: now in ON
      repeat (9) step();      // now in the 10th ON cycle
      annul_i = 1'b1;
      start_i = 1'b0;
      step();
      chk("annul_ready", 64'(ready_o), 64'd0);
      chk("annul_busy", 64'(busy_o), 64'd0);
      chk("annul_result", result_o, 64'd0);
      annul_i = 1'b0;
      run_div("after_annul", 1'b0, 32'd1000, 32'd10, 33, 32'd100, 32'd0, 1'b0, 1'b0);
      step();

      // reset mid-division
      signed_i  = 1'b0;
      opdata1_i = 32'd500;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      repeat (6) step();
      rst = 1'b1;
      step();
      chk("midrst_ready", 64'(ready_o), 64'd0);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_result", result_o, 64'd0);
      rst     = 1'b0;
      start_i = 1'b0;
      step();

      // start held in END: result holds, no second division
      run_div("hold_end", 1'b1, 32'hFFFF_FF9C, 32'd9, 33, 32'hFFFF_FFF5, 32'hFFFF_FFFF, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
